cdnsdru_usb4_message_bus_io_recal_mc: RTL and testbench

Multi-lane IORecal handler for the USB4 PHY message bus. It extends single-lane recal handling to NUM_LANES independent lanes. Per lane it tracks PHY-originated recal requests and MAC-originated recal commands, adds a programmable recal-done timeout with a status bit, and arbitrates all lanes round-robin onto the two shared message-bus write channels: PhyIORecalReq and IORecalDone. It sits between the per-lane PHY recal logic and the generic register controller's TX write path.

---
 rtl/cdnsdru_usb4_mb_io_recal_pkg.sv | 26 ++
 rtl/cdnsdru_usb4_mb_io_recal_txch.sv | 116 +++++++++++
 rtl/cdnsdru_usb4_message_bus_io_recal_mc.sv | 170 +++++++++++++++++
 tb/tb_cdnsdru_usb4_message_bus_io_recal_mc.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdnsdru_usb4_mb_io_recal_pkg.sv
// Shared encodings for the multi-lane IORecal message-bus handler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the write-channel FSM encoding, the per-lane recal FSM encoding and
// the default recal-done timeout counter width.
package cdnsdru_usb4_mb_io_recal_pkg;

  localparam int TO_W_DEF = 16;

  // Shared message-bus write channel (req channel and done channel).
  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_WR_START = 2'd1,
    CH_WR       = 2'd2
  } ch_state_t;

  // Per-lane MAC-originated recal tracking.
  typedef enum logic [1:0] {
    LN_IDLE      = 2'd0,
    LN_START     = 2'd1,
    LN_WAIT      = 2'd2,
    LN_DONE_PEND = 2'd3
  } lane_state_t;

endpackage

// File: rtl/cdnsdru_usb4_mb_io_recal_txch.sv
// Round-robin arbiter plus write FSM for one shared message-bus write channel.
// Latency: pending bit seen in IDLE -> tx_write next cycle; one IDLE cycle between writes.
// Backpressure: holds tx_write/lane until sent, then until done; pend_clr fires on sent or on done.
//
// Ports:
//   pipe_mac2phy_clk / pipe_mac2phy_rstn : clock, async active-low reset
//   soft_rst  : synchronous clear of FSM, grant and round-robin pointer
//   pend      : per-lane pending requests to arbitrate
//   sent      : register controller accepted the write (seen in WR_START)
//   wr_done   : register controller finished the write (seen in WR)
//   tx_write  : write request, high through WR_START and WR
//   lane      : granted lane, 0 whenever tx_write is low
//   pend_clr  : one-hot clear of the granted lane's pending bit
module cdnsdru_usb4_mb_io_recal_txch
  import cdnsdru_usb4_mb_io_recal_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  // 1: pend_clr fires when sent is seen; 0: fires when the write completes.
  parameter bit CLR_ON_SENT = 1'b1
) (
  input  logic                 pipe_mac2phy_clk,
  input  logic                 pipe_mac2phy_rstn,
  input  logic                 soft_rst,
  input  logic [NUM_LANES-1:0] pend,
  input  logic                 sent,
  input  logic                 wr_done,
  output logic                 tx_write,
  output logic [LANE_W-1:0]    lane,
  output logic [NUM_LANES-1:0] pend_clr
);

  ch_state_t         state_q, state_d;
  logic [LANE_W-1:0] grant_q, grant_d;
  logic [LANE_W-1:0] rr_q, rr_d;
  logic [LANE_W-1:0] hi_lane, lo_lane, pick;
  logic              hi_vld, lo_vld, pick_vld;
  logic              clr_evt;

  // First pending lane at or after rr_q; otherwise wrap to the lowest pending
  // lane. Descending scan so the last hit is the lowest index.
  always_comb begin
    hi_lane = '0;
    lo_lane = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int j = NUM_LANES - 1; j >= 0; j--) begin
      if (pend[j]) begin
        lo_lane = LANE_W'(j);
        lo_vld  = 1'b1;
        if (LANE_W'(j) >= rr_q) begin
          hi_lane = LANE_W'(j);
          hi_vld  = 1'b1;
        end
      end
    end
    pick     = hi_vld ? hi_lane : lo_lane;
    pick_vld = lo_vld;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    tx_write = 1'b0;
    lane     = '0;
    clr_evt  = 1'b0;
    pend_clr = '0;
    case (state_q)
      CH_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = CH_WR_START;
        end
      end
      CH_WR_START: begin
        tx_write = 1'b1;
        lane     = grant_q;
        if (sent) begin
          clr_evt = CLR_ON_SENT;
          state_d = CH_WR;
        end
      end
      CH_WR: begin
        tx_write = 1'b1;
        lane     = grant_q;
        if (wr_done) begin
          clr_evt = ~CLR_ON_SENT;
          state_d = CH_IDLE;
          rr_d    = (grant_q == LANE_W'(NUM_LANES - 1)) ? '0 : grant_q + LANE_W'(1);
        end
      end
      default: state_d = CH_IDLE;
    endcase
    for (int j = 0; j < NUM_LANES; j++) begin
      pend_clr[j] = clr_evt && (grant_q == LANE_W'(j));
    end
  end

  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      state_q <= CH_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else if (soft_rst) begin
      state_q <= CH_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: rtl/cdnsdru_usb4_message_bus_io_recal_mc.sv
// Multi-lane IORecal handler: per-lane PHY recal requests and MAC recal commands onto two shared MB write channels.
// Latency: p2m rising edge at T -> req write at T+2; phy_recal_done at D -> done write at D+2 at the earliest.
// Backpressure: each channel holds its write until sent/done; further requests stay pending, repeated p2m edges coalesce.
//
// Ports:
//   pipe_mac2phy_clk / pipe_mac2phy_rstn : MB clock, async active-low reset
//   mb_enable, cdb_reset, cdb_ctrl_reset  : soft resets (mb_enable low, or either cdb reset high)
//   p2m_recal_req, phy_recal_done, rx_m2p_recal_req : per-lane recal inputs
//   cfg_timeout                            : recal-done timeout in cycles, 0 disables it
//   phyiorecalreq_sent / iorecaldone_sent / prio_tx_writes_done_ior : register controller handshake
//   m2p_recal_req                          : per-lane recal command to the PHY
//   phyiorecalreq_* / iorecaldone_*        : the two channel write requests, lane and status
//   recal_err                              : sticky per-lane timeout / busy-request error
module cdnsdru_usb4_message_bus_io_recal_mc
  import cdnsdru_usb4_mb_io_recal_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int TO_W      = TO_W_DEF
) (
  input  logic                 pipe_mac2phy_clk,
  input  logic                 pipe_mac2phy_rstn,
  input  logic                 mb_enable,
  input  logic                 cdb_reset,
  input  logic                 cdb_ctrl_reset,
  input  logic [NUM_LANES-1:0] p2m_recal_req,
  input  logic [NUM_LANES-1:0] phy_recal_done,
  input  logic [NUM_LANES-1:0] rx_m2p_recal_req,
  input  logic [TO_W-1:0]      cfg_timeout,
  input  logic                 phyiorecalreq_sent,
  input  logic                 iorecaldone_sent,
  input  logic [1:0]           prio_tx_writes_done_ior,
  output logic [NUM_LANES-1:0] m2p_recal_req,
  output logic                 phyiorecalreq_tx_write,
  output logic [LANE_W-1:0]    phyiorecalreq_lane,
  output logic                 iorecaldone_tx_write,
  output logic [LANE_W-1:0]    iorecaldone_lane,
  output logic                 iorecaldone_status,
  output logic [NUM_LANES-1:0] recal_err
);

  logic                 ctrl_soft_reset;
  logic [NUM_LANES-1:0] p2m_d1, req_pend, req_clr;
  logic [NUM_LANES-1:0] done_pend, done_clr, lane_stat;

  assign ctrl_soft_reset = ~mb_enable | cdb_reset | cdb_ctrl_reset;

  // Req path: a new rising edge wins over a same-cycle clear so it is never lost.
  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      p2m_d1   <= '0;
      req_pend <= '0;
    end else if (ctrl_soft_reset) begin
      p2m_d1   <= '0;
      req_pend <= '0;
    end else begin
      p2m_d1   <= p2m_recal_req;
      req_pend <= (req_pend & ~req_clr) | (p2m_recal_req & ~p2m_d1);
    end
  end

  cdnsdru_usb4_mb_io_recal_txch #(
    .NUM_LANES   (NUM_LANES),
    .LANE_W      (LANE_W),
    .CLR_ON_SENT (1'b1)
  ) u_req_ch (
    .pipe_mac2phy_clk  (pipe_mac2phy_clk),
    .pipe_mac2phy_rstn (pipe_mac2phy_rstn),
    .soft_rst          (ctrl_soft_reset),
    .pend              (req_pend),
    .sent              (phyiorecalreq_sent),
    .wr_done           (prio_tx_writes_done_ior[0]),
    .tx_write          (phyiorecalreq_tx_write),
    .lane              (phyiorecalreq_lane),
    .pend_clr          (req_clr)
  );

  // Done channel: the lane stays in DONE_PEND until its write completes, so
  // the pending bit is released by the completion rather than by sent.
  cdnsdru_usb4_mb_io_recal_txch #(
    .NUM_LANES   (NUM_LANES),
    .LANE_W      (LANE_W),
    .CLR_ON_SENT (1'b0)
  ) u_done_ch (
    .pipe_mac2phy_clk  (pipe_mac2phy_clk),
    .pipe_mac2phy_rstn (pipe_mac2phy_rstn),
    .soft_rst          (ctrl_soft_reset),
    .pend              (done_pend),
    .sent              (iorecaldone_sent),
    .wr_done           (prio_tx_writes_done_ior[1]),
    .tx_write          (iorecaldone_tx_write),
    .lane              (iorecaldone_lane),
    .pend_clr          (done_clr)
  );

  // The granted lane sits in DONE_PEND for the whole write, so its latched
  // status is stable for the WR_START..WR window.
  assign iorecaldone_status = iorecaldone_tx_write & lane_stat[iorecaldone_lane];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_state_t     st_q, st_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            stat_q, stat_d;
    logic            err_q, err_d;
    logic            m2p_q;

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      stat_d = stat_q;
      err_d  = err_q;
      case (st_q)
        LN_IDLE: begin
          if (rx_m2p_recal_req[i]) st_d = LN_START;
        end
        LN_START: begin
          cnt_d = cfg_timeout;
          st_d  = LN_WAIT;
        end
        LN_WAIT: begin
          // Done beats a same-cycle timeout.
          if (phy_recal_done[i]) begin
            st_d   = LN_DONE_PEND;
            stat_d = 1'b0;
          end else if ((cfg_timeout != '0) && (cnt_q == TO_W'(1))) begin
            st_d   = LN_DONE_PEND;
            stat_d = 1'b1;
            err_d  = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TO_W'(1);
          end
        end
        LN_DONE_PEND: begin
          if (done_clr[i]) st_d = LN_IDLE;
        end
        default: st_d = LN_IDLE;
      endcase
      // A MAC request while this lane is busy is dropped but flagged.
      if (rx_m2p_recal_req[i] && (st_q != LN_IDLE)) err_d = 1'b1;
    end

    always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
      if (!pipe_mac2phy_rstn) begin
        st_q   <= LN_IDLE;
        cnt_q  <= '0;
        stat_q <= 1'b0;
        err_q  <= 1'b0;
        m2p_q  <= 1'b0;
      end else if (ctrl_soft_reset) begin
        st_q   <= LN_IDLE;
        cnt_q  <= '0;
        stat_q <= 1'b0;
        err_q  <= 1'b0;
        m2p_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        stat_q <= stat_d;
        err_q  <= err_d;
        m2p_q  <= (st_q == LN_START) || (st_q == LN_WAIT);
      end
    end

    assign done_pend[i]     = (st_q == LN_DONE_PEND);
    assign lane_stat[i]     = stat_q;
    assign recal_err[i]     = err_q;
    assign m2p_recal_req[i] = m2p_q;
  end

endmodule

// File: tb/tb_cdnsdru_usb4_message_bus_io_recal_mc.sv
// Bench for cdnsdru_usb4_message_bus_io_recal_mc: table-driven lane/req cases plus hand-written corner sequences.
// Expected writes are queued when stimulus is driven and compared when the DUT starts each write.
// An auto-responder answers each channel with programmable sent/done delays.
module tb_cdnsdru_usb4_message_bus_io_recal_mc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mb_enable, cdb_reset, cdb_ctrl_reset;
  logic [3:0]  p2m, phy_done, rx_m2p, m2p, recal_err;
  logic [15:0] cfg_timeout;
  logic        req_sent, done_sent;
  logic [1:0]  wr_done;
  logic        req_wr, done_wr, done_status;
  logic [1:0]  req_lane, done_lane;

  initial forever #5 clk = ~clk;

  cdnsdru_usb4_message_bus_io_recal_mc dut (
    .pipe_mac2phy_clk        (clk),
    .pipe_mac2phy_rstn       (rstn),
    .mb_enable               (mb_enable),
    .cdb_reset               (cdb_reset),
    .cdb_ctrl_reset          (cdb_ctrl_reset),
    .p2m_recal_req           (p2m),
    .phy_recal_done          (phy_done),
    .rx_m2p_recal_req        (rx_m2p),
    .cfg_timeout             (cfg_timeout),
    .phyiorecalreq_sent      (req_sent),
    .iorecaldone_sent        (done_sent),
    .prio_tx_writes_done_ior (wr_done),
    .m2p_recal_req           (m2p),
    .phyiorecalreq_tx_write  (req_wr),
    .phyiorecalreq_lane      (req_lane),
    .iorecaldone_tx_write    (done_wr),
    .iorecaldone_lane        (done_lane),
    .iorecaldone_status      (done_status),
    .recal_err               (recal_err)
  );

  typedef struct { int lane; int status; int start; int len; } wr_t;
  typedef struct { logic [3:0] mask; int n; logic [15:0] order; int s; int d; } req_vec_t;
  typedef struct { int lane; int cfg; int done_at; int dp; int status; int m2p_len; } lane_vec_t;

  wr_t q_req[$], q_done[$];
  int  n_tests = 0, n_fail = 0;
  int  cyc = 0;
  int  sdly[2], ddly[2], kcnt[2];
  bit  act[2], stable[2];
  int  st_cyc[2], hold_lane[2], hold_stat[2];
  wr_t cur[2];
  int  idle_nz = 0;
  int  m2p_run[4], m2p_last[4];

  function automatic void chk(input string nm, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, actual, expected, cyc);
    end
  endfunction

  function automatic void note_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Scoreboard side: pop an expectation at each write start, check length and hold at its end.
  function automatic void mon_ch(input int ch, input logic wr, input int lane, input int status);
    if (wr && !act[ch]) begin
      act[ch]       = 1'b1;
      stable[ch]    = 1'b1;
      st_cyc[ch]    = cyc;
      hold_lane[ch] = lane;
      hold_stat[ch] = status;
      if ((ch == 0 ? q_req.size() : q_done.size()) == 0) begin
        note_fail($sformatf("ch%0d unexpected write lane=%0d", ch, lane));
        cur[ch].len = 0;
      end else begin
        cur[ch] = (ch == 0) ? q_req.pop_front() : q_done.pop_front();
        chk($sformatf("ch%0d lane", ch), lane, cur[ch].lane);
        chk($sformatf("ch%0d start_cycle", ch), cyc, cur[ch].start);
        if (ch == 1) chk("done status", status, cur[ch].status);
      end
    end else if (wr) begin
      if (lane != hold_lane[ch] || status != hold_stat[ch]) stable[ch] = 1'b0;
    end else if (act[ch]) begin
      act[ch] = 1'b0;
      chk($sformatf("ch%0d lane/status hold", ch), int'(stable[ch]), 1);
      if (cur[ch].len > 0) chk($sformatf("ch%0d write_len", ch), cyc - st_cyc[ch], cur[ch].len);
    end
    if (!wr && (lane != 0 || status != 0)) idle_nz++;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Register-controller model: sent on the sdly-th write cycle, done ddly cycles later.
  initial begin
    req_sent = 1'b0; done_sent = 1'b0; wr_done = 2'b00;
    kcnt[0] = 0; kcnt[1] = 0;
    forever begin
      @(posedge clk); #1;
      req_sent = 1'b0; done_sent = 1'b0; wr_done = 2'b00;
      if (req_wr) begin
        if (kcnt[0] == sdly[0] - 1) req_sent = 1'b1;
        if (kcnt[0] == sdly[0] + ddly[0] - 1) wr_done[0] = 1'b1;
        kcnt[0]++;
      end else kcnt[0] = 0;
      if (done_wr) begin
        if (kcnt[1] == sdly[1] - 1) done_sent = 1'b1;
        if (kcnt[1] == sdly[1] + ddly[1] - 1) wr_done[1] = 1'b1;
        kcnt[1]++;
      end else kcnt[1] = 0;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin m2p_run[i] = 0; m2p_last[i] = -1; end
    act[0] = 1'b0; act[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      mon_ch(0, req_wr, int'(req_lane), 0);
      mon_ch(1, done_wr, int'(done_lane), int'(done_status));
      for (int i = 0; i < 4; i++) begin
        if (m2p[i]) m2p_run[i]++;
        else begin
          if (m2p_run[i] > 0) m2p_last[i] = m2p_run[i];
          m2p_run[i] = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while ((q_req.size() != 0 || q_done.size() != 0 || act[0] || act[1]) && b > 0) begin
      tick(1);
      b--;
    end
    if (b == 0) note_fail("wait_idle budget expired");
    tick(2);
  endtask

  req_vec_t  rv[4];
  lane_vec_t lv[5];
  int        t0, exp_err;
  logic [15:0] ord;

  initial begin
    rstn = 1'b0; mb_enable = 1'b1; cdb_reset = 1'b0; cdb_ctrl_reset = 1'b0;
    p2m = '0; phy_done = '0; rx_m2p = '0; cfg_timeout = '0;
    sdly[0] = 3; ddly[0] = 5; sdly[1] = 2; ddly[1] = 2;
    exp_err = 0;

    // {edge mask, writes, lane order (nibbles, first in [3:0]), sent delay, done delay}
    rv[0] = '{4'b0100, 1, 16'h0002, 3, 5};  // lane 2 alone, rr_ptr 0 -> 3
    rv[1] = '{4'b0001, 1, 16'h0000, 2, 2};  // wrap from rr_ptr 3 to lane 0 -> rr_ptr 1
    rv[2] = '{4'b1011, 3, 16'h0031, 1, 1};  // rr_ptr 1: lanes 1,3,0
    rv[3] = '{4'b1111, 4, 16'h0321, 2, 1};  // rr_ptr 1: lanes 1,2,3,0
    // {lane, cfg_timeout, phy_done offset (-1 none), DONE_PEND offset, status, m2p high cycles}
    lv[0] = '{1, 0, 10, 11, 0, 10};
    lv[1] = '{3, 20, 21, 22, 0, 21};        // done in the timeout cycle
    lv[2] = '{0, 5, 3, 4, 0, 3};
    lv[3] = '{1, 20, -1, 22, 1, 21};        // timeout
    lv[4] = '{2, 1, -1, 3, 1, 2};           // shortest timeout

    tick(3);
    chk("reset req_wr", int'(req_wr), 0);
    chk("reset done_wr", int'(done_wr), 0);
    chk("reset m2p", int'(m2p), 0);
    chk("reset recal_err", int'(recal_err), 0);
    chk("reset done_status", int'(done_status), 0);
    rstn = 1'b1;
    tick(2);
    chk("post-reset req_wr", int'(req_wr), 0);
    chk("post-reset m2p", int'(m2p), 0);

    for (int e = 0; e < 4; e++) begin
      sdly[0] = rv[e].s; ddly[0] = rv[e].d;
      t0 = cyc;
      ord = rv[e].order;
      p2m = rv[e].mask;
      for (int k = 0; k < rv[e].n; k++)
        q_req.push_back('{int'(ord[4*k +: 4]), 0, t0 + 2 + k * (rv[e].s + rv[e].d + 1), rv[e].s + rv[e].d});
      tick(1);
      p2m = '0;
      wait_idle(300);
    end

    // Second edge while still pending coalesces; an edge after the clear makes a new write.
    sdly[0] = 2; ddly[0] = 6;
    t0 = cyc;
    q_req.push_back('{2, 0, t0 + 2, 8});
    q_req.push_back('{2, 0, t0 + 11, 8});
    p2m = 4'b0100; tick(1);
    p2m = 4'b0000; tick(1);
    p2m = 4'b0100; tick(1);
    p2m = 4'b0000; tick(2);
    p2m = 4'b0100; tick(1);
    p2m = 4'b0000;
    wait_idle(300);

    for (int e = 0; e < 5; e++) begin
      t0 = cyc;
      cfg_timeout = 16'(lv[e].cfg);
      rx_m2p[lv[e].lane] = 1'b1;
      m2p_last[lv[e].lane] = -1;
      q_done.push_back('{lv[e].lane, lv[e].status, t0 + lv[e].dp + 1, 4});
      if (lv[e].status != 0) exp_err = exp_err | (1 << lv[e].lane);
      tick(1);
      rx_m2p = '0;
      if (lv[e].done_at >= 0) begin
        tick(lv[e].done_at - 1);
        phy_done[lv[e].lane] = 1'b1;
        tick(1);
        phy_done = '0;
      end
      wait_idle(300);
      chk($sformatf("lane%0d m2p_len", lv[e].lane), m2p_last[lv[e].lane], lv[e].m2p_len);
      chk($sformatf("recal_err after lane case %0d", e), int'(recal_err), exp_err);
    end

    // A second MAC request during WAIT is dropped and flagged.
    cfg_timeout = '0;
    t0 = cyc;
    m2p_last[0] = -1;
    q_done.push_back('{0, 0, t0 + 10, 4});
    rx_m2p = 4'b0001; tick(1);
    rx_m2p = 4'b0000; tick(3);
    rx_m2p = 4'b0001; tick(1);
    rx_m2p = 4'b0000; tick(3);
    phy_done = 4'b0001; tick(1);
    phy_done = 4'b0000;
    wait_idle(300);
    exp_err = exp_err | 1;
    chk("busy rx m2p_len", m2p_last[0], 8);
    chk("busy rx recal_err", int'(recal_err), exp_err);

    // Soft reset while both channels sit in WR.
    sdly[0] = 1; ddly[0] = 50; sdly[1] = 1; ddly[1] = 50;
    t0 = cyc;
    q_req.push_back('{3, 0, t0 + 2, 0});
    q_done.push_back('{2, 0, t0 + 4, 0});
    p2m = 4'b1000; rx_m2p = 4'b0100; tick(1);
    p2m = 4'b0000; rx_m2p = 4'b0000; tick(1);
    phy_done = 4'b0100; tick(1);
    phy_done = 4'b0000; tick(3);
    chk("pre-soft-reset req_wr", int'(req_wr), 1);
    chk("pre-soft-reset done_wr", int'(done_wr), 1);
    cdb_ctrl_reset = 1'b1; tick(1);
    cdb_ctrl_reset = 1'b0;
    chk("soft reset req_wr", int'(req_wr), 0);
    chk("soft reset done_wr", int'(done_wr), 0);
    chk("soft reset req_lane", int'(req_lane), 0);
    chk("soft reset done_lane", int'(done_lane), 0);
    chk("soft reset recal_err", int'(recal_err), 0);
    chk("soft reset m2p", int'(m2p), 0);
    tick(2);

    // Both round-robin pointers restart from lane 0; channels run concurrently.
    sdly[0] = 2; ddly[0] = 2; sdly[1] = 2; ddly[1] = 2;
    t0 = cyc;
    q_req.push_back('{1, 0, t0 + 2, 4});
    q_req.push_back('{3, 0, t0 + 7, 4});
    q_done.push_back('{0, 0, t0 + 4, 4});
    q_done.push_back('{2, 0, t0 + 9, 4});
    p2m = 4'b1010; rx_m2p = 4'b0101; tick(1);
    p2m = 4'b0000; rx_m2p = 4'b0000; tick(1);
    phy_done = 4'b0101; tick(1);
    phy_done = 4'b0000;
    wait_idle(300);
    chk("post soft reset recal_err", int'(recal_err), 0);

    tick(5);
    chk("lane/status zero while idle (violations)", idle_nz, 0);
    chk("req expectations left", q_req.size(), 0);
    chk("done expectations left", q_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
